uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with a start bit, WIDTH data bits, an optional
// even-parity bit and one stop bit. Each bit is held for DIVISOR clk cycles.
// Optional feature: define UART_TX_PARITY_EN to add the PARITY state and its bit.
module uart_tx #(
    parameter int WIDTH         = 8,
    parameter int DIVISOR       = 100,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_data_valid,
    output logic             o_ready,
    output logic             o_tx
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BIT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             tx_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    // Bit that leaves the shift register next, chosen by the configured order.
    function automatic logic next_bit(input logic [WIDTH-1:0] sr);
        return LITTLE_ENDIAN ? sr[0] : sr[WIDTH-1];
    endfunction

    // Shift register after the outgoing bit has been consumed.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] sr);
        return LITTLE_ENDIAN ? (sr >> 1) : (sr << 1);
    endfunction

    // Ready is decoded straight from the state so a new word is taken in IDLE only.
    assign o_ready = (state_q == S_IDLE);
    assign o_tx    = tx_q;

    // Frame sequencer: state, bit timing, shift register and the registered line.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    cnt_q <= '0;
                    if (i_data_valid) begin
                        // The word is captured once here; the input is ignored afterwards.
                        shreg_q   <= i_data;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^i_data;
`endif
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= next_bit(shreg_q);
                        shreg_q   <= shift_out(shreg_q);
                        state_q   <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= next_bit(shreg_q);
                            shreg_q   <= shift_out(shreg_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives an LSB-first and an MSB-first uart_tx in lockstep and
// compares whole serial frames against a bit-list model of the frame format.
module tb_uart_tx;

    localparam int W = 8;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME_LEN = NBITS * D;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic [W-1:0] i_data;
    logic         i_data_valid;
    logic         o_ready_le, o_tx_le;
    logic         o_ready_be, o_tx_be;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(1'b1)) dut_le (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_ready      (o_ready_le),
        .o_tx         (o_tx_le)
    );

    uart_tx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_ready      (o_ready_be),
        .o_tx         (o_tx_be)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference frame: list of line levels per bit, each stretched to D cycles.
    function automatic logic [63:0] model_wave(input logic [W-1:0] w, input bit le);
        logic        bits [NBITS];
        logic [63:0] wave;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++)
            bits[1 + i] = le ? w[i] : w[W - 1 - i];
`ifdef UART_TX_PARITY_EN
        bits[W + 1] = ^w;
`endif
        bits[NBITS - 1] = 1'b1;
        wave = '0;
        for (int k = 0; k < FRAME_LEN; k++)
            wave[k] = bits[k / D];
        return wave;
    endfunction

    // Expects an accept on the coming edge; records the frame one sample per cycle,
    // scrambles i_data throughout, and ends at the negedge of the idle cycle.
    task automatic capture_frame(input string tag, input logic [W-1:0] w, input bit hold,
                                 input logic [W-1:0] nxt,
                                 output logic [63:0] obs_le, output logic [63:0] obs_be);
        logic [63:0] rdy;
        obs_le = '0;
        obs_be = '0;
        rdy    = '0;
        @(posedge clk);
        for (int k = 0; k < FRAME_LEN; k++) begin
            @(negedge clk);
            obs_le[k] = o_tx_le;
            obs_be[k] = o_tx_be;
            rdy[k]    = o_ready_le | o_ready_be;
            i_data    = W'($urandom);
            if (!hold) i_data_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_le_wave"}, obs_le, model_wave(w, 1'b1));
        chk({tag, "_be_wave"}, obs_be, model_wave(w, 1'b0));
        chk({tag, "_busy_rdy"}, rdy, 64'd0);
        chk({tag, "_idle"}, {62'd0, o_ready_le & o_ready_be, o_tx_le & o_tx_be}, 64'd3);
        if (hold) i_data = nxt;
    endtask

    logic [63:0] obs_le, obs_be;
    logic [W-1:0] w, nw;
    logic         quiet;
    bit           hold;

    initial begin
        i_reset_n    = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {62'd0, o_tx_le, o_tx_be}, 64'd3);
        chk("rst_rdy", {62'd0, o_ready_le, o_ready_be}, 64'd3);
        i_reset_n = 1'b1;
        @(negedge clk);

        // 0x01: fixed waveforms written out by hand, then the model comparison
        i_data = 8'h01; i_data_valid = 1'b1;
        capture_frame("x01", 8'h01, 1'b0, 8'h00, obs_le, obs_be);
`ifdef UART_TX_PARITY_EN
        chk("x01_parity", {63'd0, obs_le[38]}, 64'd1);
        chk("x01_len_stop", obs_le[43:40], 64'hF);
`else
        chk("x01_le_fixed", obs_le, 64'h000000F0000000F0);
        chk("x01_be_fixed", obs_be, 64'h000000FF00000000);
`endif

        // Back-to-back with valid held: 0xA5 then 0x5A, start-to-start FRAME_LEN+1
        i_data = 8'hA5; i_data_valid = 1'b1;
        capture_frame("xA5", 8'hA5, 1'b1, 8'h5A, obs_le, obs_be);
`ifdef UART_TX_PARITY_EN
        chk("xA5_parity", {63'd0, obs_le[38]}, 64'd0);
`endif
        capture_frame("x5A", 8'h5A, 1'b0, 8'h00, obs_le, obs_be);

        // Reset during data bit 3 of 0xFF, with valid high on the reset edge
        i_data = 8'hFF; i_data_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            i_data_valid = 1'b0;
        end
        i_reset_n = 1'b0; i_data = 8'hAA; i_data_valid = 1'b1;
        @(negedge clk);
        i_reset_n = 1'b1; i_data_valid = 1'b0;
        chk("midrst_tx", {62'd0, o_tx_le, o_tx_be}, 64'd3);
        chk("midrst_rdy", {62'd0, o_ready_le, o_ready_be}, 64'd3);
        quiet = 1'b1;
        for (int k = 0; k < 2 * D; k++) begin
            @(negedge clk);
            quiet = quiet & o_tx_le & o_tx_be & o_ready_le & o_ready_be;
        end
        chk("midrst_quiet", {63'd0, quiet}, 64'd1);
        i_data = 8'h0F; i_data_valid = 1'b1;
        capture_frame("x0F", 8'h0F, 1'b0, 8'h00, obs_le, obs_be);

        // 0x3C with i_data scrambled every cycle of the frame
        i_data = 8'h3C; i_data_valid = 1'b1;
        capture_frame("x3C", 8'h3C, 1'b0, 8'h00, obs_le, obs_be);

        // Randomized words, alternating held-valid and dropped-valid chaining
        w = W'($urandom);
        i_data = w; i_data_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            nw   = W'($urandom);
            hold = (n % 2 == 0);
            capture_frame("rnd", w, hold, nw, obs_le, obs_be);
            if (!hold) begin
                i_data = nw;
                i_data_valid = 1'b1;
            end
            w = nw;
        end
        capture_frame("rnd_last", w, 1'b0, 8'h00, obs_le, obs_be);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
